accumulator_sequencer: RTL and testbench

Command-driven micro-sequencer for the adder/accumulator datapath. It accepts one operation per valid/ready handshake and expands it into the timed sequence of datapath controls: A load, B load, A bus enable, ALU bus enable and subtract select. It captures carry/zero flags and bus read-back, then reports completion with a one-cycle `done` pulse. It replaces the manual `uio_in` control strobes at the top level and sits between the host pins and the `alu`/`accumulator_register` instances.

---
 rtl/accumulator_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_accumulator_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_sequencer.sv
// Command micro-sequencer for the adder/accumulator datapath.
// Optional 2-entry command FIFO: define ACC_SEQ_CMD_FIFO_EN.
`timescale 1ns/1ps
module accumulator_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic         cmd_ready,
  output logic [W-1:0] drv_data,
  output logic         nLa,
  output logic         nLb,
  output logic         Ea,
  output logic         Eu,
  output logic         sub,
  input  logic [W-1:0] bus_in,
  input  logic         cf_in,
  input  logic         zf_in,
  output logic [W-1:0] result,
  output logic         cf,
  output logic         zf,
  output logic         done,
  output logic         err,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LDA, S_LDB, S_EXE, S_OUT, S_DONE
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OUT = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  state_t       state, nxt;
  logic [2:0]   op_q, nxt_op, hd_op;
  logic [W-1:0] data_q, nxt_data, hd_data;
  logic         start;

  logic [W-1:0] d_drv;
  logic         d_nla, d_nlb, d_ea, d_eu, d_sub, d_done;

`ifdef ACC_SEQ_CMD_FIFO_EN
  logic [2:0]   f_op   [2];
  logic [W-1:0] f_data [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  logic         push, pop;

  assign cmd_ready = (cnt != 2'd2);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = start;
  assign hd_op     = f_op[rp];
  assign hd_data   = f_data[rp];
  // Chain straight out of DONE when another command is waiting.
  assign start     = (cnt != 2'd0) &
                     ((state == S_IDLE) | (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_op[wp]   <= cmd_op;
      f_data[wp] <= cmd_data;
    end
  end
`else
  assign cmd_ready = (state == S_IDLE);
  assign hd_op     = cmd_op;
  assign hd_data   = cmd_data;
  assign start     = cmd_valid & (state == S_IDLE);
`endif

  always_comb begin
    nxt      = state;
    nxt_op   = op_q;
    nxt_data = data_q;
    if (start) begin
      nxt_op   = hd_op;
      nxt_data = (hd_op == OP_CLR) ? '0 : hd_data;
      case (hd_op)
        OP_LDA, OP_CLR: nxt = S_LDA;
        OP_ADD, OP_SUB: nxt = S_LDB;
        OP_OUT:         nxt = S_OUT;
        default:        nxt = S_DONE;
      endcase
    end else begin
      case (state)
        S_LDA:   nxt = S_DONE;
        S_LDB:   nxt = S_EXE;
        S_EXE:   nxt = S_DONE;
        S_OUT:   nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        default: nxt = state;
      endcase
    end
  end

  // Controls are decoded from the next state so they register cleanly.
  always_comb begin
    d_drv  = '0;
    d_nla  = 1'b1;
    d_nlb  = 1'b1;
    d_ea   = 1'b0;
    d_eu   = 1'b0;
    d_sub  = 1'b0;
    d_done = 1'b0;
    unique case (1'b1)
      nxt == S_LDA: begin
        d_drv = nxt_data;
        d_nla = 1'b0;
      end
      nxt == S_LDB: begin
        d_drv = nxt_data;
        d_nlb = 1'b0;
      end
      nxt == S_EXE: begin
        d_nla = 1'b0;
        d_eu  = 1'b1;
        d_sub = (nxt_op == OP_SUB);
      end
      nxt == S_OUT:  d_ea   = 1'b1;
      nxt == S_DONE: d_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      data_q   <= '0;
      drv_data <= '0;
      nLa      <= 1'b1;
      nLb      <= 1'b1;
      Ea       <= 1'b0;
      Eu       <= 1'b0;
      sub      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      op_q     <= nxt_op;
      data_q   <= nxt_data;
      drv_data <= d_drv;
      nLa      <= d_nla;
      nLb      <= d_nlb;
      Ea       <= d_ea;
      Eu       <= d_eu;
      sub      <= d_sub;
      done     <= d_done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      cf     <= 1'b0;
      zf     <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (state == S_OUT) result <= bus_in;
      if (state == S_DONE &&
          (op_q == OP_ADD || op_q == OP_SUB)) begin
        cf <= cf_in;
        zf <= zf_in;
      end
      if (start) err <= (hd_op[2] & hd_op[1]);
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Scoreboard bench for accumulator_sequencer with a behavioural
// A/B register + ALU datapath closing the bus loop.
`timescale 1ns/1ps
module tb_accumulator_sequencer;
  localparam int W = 8;
  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] LDA = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] SUB = 3'd3;
  localparam logic [2:0] OUT = 3'd4;
  localparam logic [2:0] CLR = 3'd5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_ready;
  logic [W-1:0] drv_data;
  logic         nLa, nLb, Ea, Eu, sub;
  logic [W-1:0] bus_in;
  logic         cf_in, zf_in;
  logic [W-1:0] result;
  logic         cf, zf, done, err, busy;

  always #5 clk = ~clk;

  accumulator_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .drv_data(drv_data), .nLa(nLa), .nLb(nLb),
    .Ea(Ea), .Eu(Eu), .sub(sub),
    .bus_in(bus_in), .cf_in(cf_in), .zf_in(zf_in),
    .result(result), .cf(cf), .zf(zf),
    .done(done), .err(err), .busy(busy)
  );

  // Datapath model: ALU flags are latched when the ALU drives the bus.
  logic [W-1:0] a_reg = '0;
  logic [W-1:0] b_reg = '0;
  logic         fc = 1'b0;
  logic         fz = 1'b0;
  logic [W:0]   sum9;

  assign sum9 = sub ? ({1'b0, a_reg} + {1'b0, ~b_reg} + 9'd1)
                    : ({1'b0, a_reg} + {1'b0, b_reg});
  assign bus_in = Ea ? a_reg : (Eu ? sum9[W-1:0] : drv_data);
  assign cf_in  = fc;
  assign zf_in  = fz;

  always @(posedge clk) begin
    if (!nLa) a_reg <= bus_in;
    if (!nLb) b_reg <= bus_in;
    if (Eu) begin
      fc <= sum9[W];
      fz <= (sum9[W-1:0] == '0);
    end
  end

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ACC_SEQ_CMD_FIFO_EN
  bit timed = 1'b0;
`else
  bit timed = 1'b1;
`endif
  bit idle_en = 1'b0;
  bit pend = 1'b0;

  typedef struct {
    int          cyc;
    logic [14:0] v;
  } ctl_t;
  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
  } rsp_t;

  ctl_t ctlq[$];
  rsp_t rspq[$];

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // {drv, nLa, nLb, Ea, Eu, sub, done, err}
  function automatic logic [14:0] cv(logic [7:0] d, logic a,
      logic b, logic ea, logic eu, logic s, logic dn, logic er);
    return {d, a, b, ea, eu, s, dn, er};
  endfunction

  function automatic logic [14:0] vnow();
    return {drv_data, nLa, nLb, Ea, Eu, sub, done, err};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [7:0] d,
                       input logic [7:0] r, input logic c,
                       input logic z);
    int   n;
    bit   ok;
    logic il;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    n  = cyc + 1;
    il = op[2] & op[1];
    rspq.push_back('{r, c, z});
    if (timed) begin
      case (op)
        LDA, CLR: begin
          ctlq.push_back('{n, cv((op == CLR) ? 8'h00 : d,
                                 0, 1, 0, 0, 0, 0, 0)});
          ctlq.push_back('{n + 1, cv(0, 1, 1, 0, 0, 0, 1, 0)});
        end
        ADD, SUB: begin
          ctlq.push_back('{n, cv(d, 1, 0, 0, 0, 0, 0, 0)});
          ctlq.push_back('{n + 1, cv(0, 0, 1, 0, 1,
                                     (op == SUB), 0, 0)});
          ctlq.push_back('{n + 2, cv(0, 1, 1, 0, 0, 0, 1, 0)});
        end
        OUT: begin
          ctlq.push_back('{n, cv(0, 1, 1, 1, 0, 0, 0, 0)});
          ctlq.push_back('{n + 1, cv(0, 1, 1, 0, 0, 0, 1, 0)});
        end
        default:
          ctlq.push_back('{n, cv(0, 1, 1, 0, 0, 0, 1, il)});
      endcase
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Monitor: flags/result checked the cycle after each done pulse.
  always @(negedge clk) begin
    rsp_t e;
    ctl_t x;
    if (rst) begin
      pend = 1'b0;
    end else begin
      chk("ea_eu_excl", {31'd0, Ea & Eu}, 0);
      chk("nla_nlb_excl", {31'd0, !nLa & !nLb}, 0);
      if (pend) begin
        pend = 1'b0;
        if (rspq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = rspq.pop_front();
          chk("result", {24'd0, result}, {24'd0, e.res});
          chk("cf", {31'd0, cf}, {31'd0, e.c});
          chk("zf", {31'd0, zf}, {31'd0, e.z});
        end
      end
      if (timed) begin
        while (ctlq.size() > 0 && ctlq[0].cyc < cyc) begin
          x = ctlq.pop_front();
          chk("ctl_missed", 0, x.v);
        end
        if (ctlq.size() > 0 && ctlq[0].cyc == cyc) begin
          x = ctlq.pop_front();
          chk("ctl", {17'd0, vnow()}, {17'd0, x.v});
        end else if (idle_en) begin
          chk("idle_ctl", {18'd0, vnow() >> 1},
              {18'd0, cv(0, 1, 1, 0, 0, 0, 0, 0) >> 1});
        end
      end
      if (done) pend = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int nd, gaps;
    repeat (2) @(negedge clk);
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_flags", {29'd0, cf, zf, err}, 0);
    chk("rst_done_busy", {30'd0, done, busy}, 0);
    chk("rst_ctl", {17'd0, vnow()},
        {17'd0, cv(0, 1, 1, 0, 0, 0, 0, 0)});
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, cmd_ready}, 1);

    // Reset in the middle of an ADD.
    cmd_valid = 1'b1;
    cmd_op    = ADD;
    cmd_data  = 8'h09;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (Eu) begin
        seen = 1'b1;
        break;
      end
    end
    chk("exe_reached", {31'd0, seen}, 1);
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {17'd0, vnow()},
        {17'd0, cv(0, 1, 1, 0, 0, 0, 0, 0)});
    chk("midrst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 1);
    chk("post_rst_done_busy", {30'd0, done, busy}, 0);
    idle_en = 1'b1;

    issue(LDA, 8'h05, 8'h00, 0, 0);
    issue(ADD, 8'h03, 8'h00, 0, 0);
    issue(OUT, 8'h00, 8'h08, 0, 0);

    issue(LDA, 8'h02, 8'h08, 0, 0);
    issue(SUB, 8'h02, 8'h08, 1, 1);
    issue(CLR, 8'h77, 8'h08, 1, 1);
    issue(OUT, 8'h00, 8'h00, 1, 1);

    issue(LDA, 8'h80, 8'h00, 1, 1);
    issue(SUB, 8'h01, 8'h00, 1, 0);
    issue(OUT, 8'h00, 8'h7F, 1, 0);

    issue(LDA, 8'hF0, 8'h7F, 1, 0);
    issue(ADD, 8'h10, 8'h7F, 1, 1);
    issue(OUT, 8'h00, 8'h00, 1, 1);

    issue(3'd7, 8'hAA, 8'h00, 1, 1);
    issue(NOP, 8'h00, 8'h00, 1, 1);
    issue(3'd6, 8'h55, 8'h00, 1, 1);
    issue(LDA, 8'h33, 8'h00, 1, 1);
    issue(OUT, 8'h00, 8'h33, 1, 1);

`ifdef ACC_SEQ_CMD_FIFO_EN
    nd   = 0;
    gaps = 0;
    fork
      begin
        issue(LDA, 8'h01, 8'h33, 1, 1);
        issue(ADD, 8'h01, 8'h33, 0, 0);
        issue(ADD, 8'h01, 8'h33, 0, 0);
        issue(OUT, 8'h00, 8'h03, 0, 0);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (busy) seen = 1'b1;
          if (seen) begin
            if (done) nd++;
            if (nd == 4) break;
            if (!busy) gaps++;
          end
        end
      end
    join
    chk("fifo_dones", nd, 4);
    chk("fifo_idle_gaps", gaps, 0);
`endif

    for (int i = 0; i < 50; i++) begin
      if (rspq.size() == 0 && !pend) break;
      @(negedge clk);
    end
    chk("drain_rsp", rspq.size(), 0);
    chk("drain_ctl", ctlq.size(), 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
